// File: rtl/irq_ctrl18_pkg.sv
// Shared constants for the Core18 interrupt controller: register map, vector and data widths.
package irq18_pkg;
   localparam int VEC_W  = 4;
   localparam int DATA_W = 18;

   localparam logic [1:0] REG_ENABLE  = 2'd0;
   localparam logic [1:0] REG_PENDING = 2'd1;
   localparam logic [1:0] REG_MODE    = 2'd2;
   localparam logic [1:0] REG_SWTRIG  = 2'd3;
endpackage

// File: rtl/irq_ctrl18_if.sv
// Core-side bus of the interrupt controller: request lines, acknowledge, port I/O and vector.
interface irq_ctrl18_if #(
   parameter int NUM_CH = 8,
   parameter int ADRS_W = 2
);
   import irq18_pkg::*;

   logic [NUM_CH-1:0] irq;
   logic              int_ack;
   logic              port_wr;
   logic              port_rd;
   logic [ADRS_W-1:0] adrs;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic [VEC_W-1:0]  vector;

   modport master (
      output irq, int_ack, port_wr, port_rd, adrs, din,
      input  dout, vector
   );

   modport slave (
      input  irq, int_ack, port_wr, port_rd, adrs, din,
      output dout, vector
   );
endinterface

// File: rtl/irq_ctrl18_prio_enc.sv
// Lowest-index-first priority encoder: valid when any request is set, idx of the winner.
module irq_prio_enc
   import irq18_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0]     req,
   output logic             valid,
   output logic [VEC_W-1:0] idx
);

   assign valid = |req;

   // Scan from the top so the lowest set index is the last one written.
   always_comb begin
      idx = {VEC_W{1'b0}};
      for (int i = N - 1; i >= 0; i--) begin
         idx = req[i] ? VEC_W'(i) : idx;
      end
   end

endmodule

// File: rtl/irq_ctrl18.sv
// Interrupt controller for the Core18 VECTOR input; define IRQ_SYNC_EN to add a
// 2-flop synchroniser on the request lines (IRQ->VECTOR latency 4 instead of 2).
module irq_ctrl18
   import irq18_pkg::*;
#(
   parameter int NUM_CH   = 8,
   parameter int VEC_BASE = 1,
   parameter int ADRS_W   = 2
) (
   input logic         clk,
   input logic         rst,
   input logic         srst,
   irq_ctrl18_if.slave bus
);

   if (NUM_CH < 1 || NUM_CH > 15 || VEC_BASE < 1 || VEC_BASE + NUM_CH - 1 > 15) begin : g_bad_cfg
      $error("irq_ctrl18: NUM_CH/VEC_BASE do not fit the 4-bit vector space");
   end

   logic [NUM_CH-1:0] irq_s, irq_q_r, rise_s, din_ch_s;
   logic [NUM_CH-1:0] enable_r, pending_r, mode_r, pending_nxt_s;
   logic [NUM_CH-1:0] set_s, clr_s, ack_oh_s, ack_eff_s, req_s;
   logic              wr_en_s, wr_pend_s, wr_mode_s, wr_sw_s, prio_valid_s;
   logic [VEC_W-1:0]  prio_idx_s, act_idx_r, vector_r, vector_nxt_s;
   logic [DATA_W-1:0] rdata_s, dout_r;

`ifdef IRQ_SYNC_EN
   logic [NUM_CH-1:0] sync1_r, sync2_r;

   // Two-stage synchroniser for asynchronous request lines.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= {NUM_CH{1'b0}};
         sync2_r <= {NUM_CH{1'b0}};
      end else if (srst) begin
         sync1_r <= {NUM_CH{1'b0}};
         sync2_r <= {NUM_CH{1'b0}};
      end else begin
         sync1_r <= bus.irq;
         sync2_r <= sync1_r;
      end
   end
   assign irq_s = sync2_r;
`else
   assign irq_s = bus.irq;
`endif

   assign din_ch_s  = bus.din[NUM_CH-1:0];
   assign rise_s    = irq_s & ~irq_q_r;
   assign wr_en_s   = bus.port_wr && (bus.adrs == ADRS_W'(REG_ENABLE));
   assign wr_pend_s = bus.port_wr && (bus.adrs == ADRS_W'(REG_PENDING));
   assign wr_mode_s = bus.port_wr && (bus.adrs == ADRS_W'(REG_MODE));
   assign wr_sw_s   = bus.port_wr && (bus.adrs == ADRS_W'(REG_SWTRIG));

   // Pending update: edge bits set-wins over ACK/W1C, level bits follow the line.
   always_comb begin
      ack_oh_s = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         ack_oh_s[i] = bus.int_ack && (vector_r != {VEC_W{1'b0}}) && (act_idx_r == VEC_W'(i));
      end
      set_s         = rise_s | (wr_sw_s ? din_ch_s : {NUM_CH{1'b0}});
      clr_s         = ack_oh_s | (wr_pend_s ? din_ch_s : {NUM_CH{1'b0}});
      ack_eff_s     = ack_oh_s & mode_r & ~set_s;
      pending_nxt_s = (mode_r & ((pending_r & ~clr_s) | set_s)) | (~mode_r & irq_s);
      // The acknowledged source is withheld so the core never sees it twice.
      req_s         = pending_r & enable_r & ~ack_eff_s;
   end

   irq_prio_enc #(.N(NUM_CH)) u_prio (
      .req   (req_s),
      .valid (prio_valid_s),
      .idx   (prio_idx_s)
   );

   assign vector_nxt_s = prio_valid_s ? (VEC_W'(VEC_BASE) + prio_idx_s) : {VEC_W{1'b0}};

   // Register read mux; SWTRIG and unused addresses read zero.
   always_comb begin
      rdata_s = {DATA_W{1'b0}};
      case (bus.adrs)
         ADRS_W'(REG_ENABLE):  rdata_s[NUM_CH-1:0] = enable_r;
         ADRS_W'(REG_PENDING): rdata_s[NUM_CH-1:0] = pending_r;
         ADRS_W'(REG_MODE):    rdata_s[NUM_CH-1:0] = mode_r;
         default:              rdata_s = {DATA_W{1'b0}};
      endcase
   end

   // Controller state, vector and read-data registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enable_r  <= {NUM_CH{1'b0}};
         pending_r <= {NUM_CH{1'b0}};
         mode_r    <= {NUM_CH{1'b1}};
         irq_q_r   <= {NUM_CH{1'b0}};
         vector_r  <= {VEC_W{1'b0}};
         act_idx_r <= {VEC_W{1'b0}};
         dout_r    <= {DATA_W{1'b0}};
      end else if (srst) begin
         enable_r  <= {NUM_CH{1'b0}};
         pending_r <= {NUM_CH{1'b0}};
         mode_r    <= {NUM_CH{1'b1}};
         irq_q_r   <= {NUM_CH{1'b0}};
         vector_r  <= {VEC_W{1'b0}};
         act_idx_r <= {VEC_W{1'b0}};
         dout_r    <= {DATA_W{1'b0}};
      end else begin
         enable_r  <= wr_en_s ? din_ch_s : enable_r;
         mode_r    <= wr_mode_s ? din_ch_s : mode_r;
         pending_r <= pending_nxt_s;
         irq_q_r   <= irq_s;
         vector_r  <= vector_nxt_s;
         act_idx_r <= prio_idx_s;
         dout_r    <= bus.port_rd ? rdata_s : {DATA_W{1'b0}};
      end
   end

   assign bus.dout   = dout_r;
   assign bus.vector = vector_r;

endmodule
